io_arbiter: RTL and testbench

//  Shares the CPU read port of the IO peripheral between NUM_SRC receive byte queues:

---
 rtl/io_arbiter_pkg.sv | 44 ++++
 rtl/io_arbiter_rr_arbiter.sv | 37 +++
 rtl/io_arbiter.sv | 112 +++++++++++
 tb/tb_io_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/io_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_arbiter_pkg
//  Purpose  : Shared bus widths, IO register addresses, status-word field
//             positions and the read-address decode for the IO read arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package io_arbiter_pkg;

    // CPU bus geometry
    localparam int ADDR_SIZE = 16;
    localparam int WORD_SIZE = 16;

    // IO register addresses on read_bus
    localparam logic [ADDR_SIZE-1:0] IO_POP    = 16'hFF00;
    localparam logic [ADDR_SIZE-1:0] IO_STATUS = 16'hFF01;

    // Tagged-pop word layout, shared with the software header
    localparam int VALID_BIT = 15;
    localparam int ID_LSB    = 8;

    // Kind of access presented on read_bus this cycle
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_POP  = 2'd1,
        RD_STAT = 2'd2
    } rd_kind_e;

    function automatic rd_kind_e rd_decode(
        input logic [ADDR_SIZE-1:0] addr,
        input logic [ADDR_SIZE-1:0] pop_addr,
        input logic [ADDR_SIZE-1:0] stat_addr
    );
        if (addr == pop_addr) begin
            return RD_POP;
        end
        if (addr == stat_addr) begin
            return RD_STAT;
        end
        return RD_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. Scans last+1, last+2, ...
//             modulo N and returns the first requesting index.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import io_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         any,
    output logic [W-1:0] grant
);

    logic [W-1:0] idx;

    // Walk candidates from farthest to nearest so the nearest requester wins
    always_comb begin
        any   = 1'b0;
        grant = '0;
        idx   = '0;
        for (int off = N; off >= 1; off--) begin
            idx = W'((int'(last) + off) % N);
            if (req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : io_arbiter
//  Purpose  : Shares the CPU read port between NUM_SRC receive byte queues.
//             A POP read returns a tagged byte from the round-robin winner
//             and pops that source; a STATUS read returns raw src_valid.
//  Revision : 1.0  initial release
// ============================================================================
module io_arbiter
    import io_arbiter_pkg::*;
#(
    parameter int                    NUM_SRC   = 4,
    parameter int                    SRC_W     = 2,
    parameter logic [ADDR_SIZE-1:0]  POP_ADDR  = IO_POP,
    parameter logic [ADDR_SIZE-1:0]  STAT_ADDR = IO_STATUS
) (
    input  logic                   reset,
    input  logic                   read_clk,
    input  logic [ADDR_SIZE-1:0]   read_bus,
    inout  wire  [WORD_SIZE-1:0]   data_bus,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [NUM_SRC*8-1:0]   src_data,
    output logic [NUM_SRC-1:0]     src_pop,
    output logic                   irq
);

    logic                 out_en_q,     out_en_d;
    logic [WORD_SIZE-1:0] out_buffer_q, out_buffer_d;
    logic [NUM_SRC-1:0]   src_pop_q,    src_pop_d;
    logic [NUM_SRC-1:0]   pop_mask_q,   pop_mask_d;
    logic [SRC_W-1:0]     last_grant_q, last_grant_d;
    logic                 irq_q,        irq_d;

    logic [NUM_SRC-1:0]   eligible;
    logic                 any;
    logic [SRC_W-1:0]     grant;
    rd_kind_e             rd_kind;
    logic [7:0]           src_byte [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src_byte
        assign src_byte[i] = src_data[8*i +: 8];
    end

    // A source popped last cycle may still show a stale not-empty flag
    assign eligible = src_valid & ~pop_mask_q;

    rr_arbiter #(
        .N (NUM_SRC),
        .W (SRC_W)
    ) u_rr (
        .req   (eligible),
        .last  (last_grant_q),
        .any   (any),
        .grant (grant)
    );

    // Next-state for the read port, pop pulse, grant pointer and interrupt
    always_comb begin
        rd_kind      = rd_decode(read_bus, POP_ADDR, STAT_ADDR);
        out_en_d     = 1'b0;
        out_buffer_d = out_buffer_q;
        src_pop_d    = '0;
        last_grant_d = last_grant_q;
        irq_d        = |eligible;
        case (rd_kind)
            RD_POP: begin
                out_en_d     = 1'b1;
                out_buffer_d = '0;
                if (any) begin
                    out_buffer_d[VALID_BIT]         = 1'b1;
                    out_buffer_d[ID_LSB +: SRC_W]   = grant;
                    out_buffer_d[7:0]               = src_byte[grant];
                    src_pop_d                       = NUM_SRC'(1) << grant;
                    last_grant_d                    = grant;
                end
            end
            RD_STAT: begin
                out_en_d                     = 1'b1;
                out_buffer_d                 = '0;
                out_buffer_d[NUM_SRC-1:0]    = src_valid;
            end
            default: begin
            end
        endcase
        pop_mask_d = src_pop_d;
    end

    // Register all state; reset releases the bus and cancels any pending pop
    always_ff @(posedge read_clk or posedge reset) begin
        if (reset) begin
            out_en_q     <= 1'b0;
            out_buffer_q <= '0;
            src_pop_q    <= '0;
            pop_mask_q   <= '0;
            last_grant_q <= SRC_W'(NUM_SRC - 1);
            irq_q        <= 1'b0;
        end else begin
            out_en_q     <= out_en_d;
            out_buffer_q <= out_buffer_d;
            src_pop_q    <= src_pop_d;
            pop_mask_q   <= pop_mask_d;
            last_grant_q <= last_grant_d;
            irq_q        <= irq_d;
        end
    end

    assign data_bus = out_en_q ? out_buffer_q : {WORD_SIZE{1'bz}};
    assign src_pop  = src_pop_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_io_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_arbiter
//  Purpose  : Self-checking bench for io_arbiter. The data bus is pulled up,
//             so a released bus reads as 16'hFFFF.
//  Revision : 1.0  initial release
// ============================================================================
module tb_io_arbiter;

    localparam logic [15:0] A_POP  = 16'hFF00;
    localparam logic [15:0] A_STAT = 16'hFF01;
    localparam logic [15:0] A_NONE = 16'h1234;
    localparam logic [15:0] BUS_Z  = 16'hFFFF;
    localparam logic [31:0] D_ALL  = 32'hD3C2B1A0;

    logic        reset;
    logic        read_clk;
    logic [15:0] read_bus;
    wire  [15:0] data_bus;
    logic [3:0]  src_valid;
    logic [31:0] src_data;
    logic [3:0]  src_pop;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst_before;
        logic [15:0] addr;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [15:0] exp_bus;
        logic [3:0]  exp_pop;
        logic        exp_irq;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] bus;
        logic [3:0]  pop;
        logic        irq;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    for (genvar i = 0; i < 16; i++) begin : g_pull
        pullup (data_bus[i]);
    end

    io_arbiter dut (
        .reset     (reset),
        .read_clk  (read_clk),
        .read_bus  (read_bus),
        .data_bus  (data_bus),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_pop   (src_pop),
        .irq       (irq)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop one expectation and compare it against the DUT outputs
    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: empty queue got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        check({e.name, ".bus"}, data_bus, e.bus);
        check({e.name, ".pop"}, {12'h0, src_pop}, {12'h0, e.pop});
        check({e.name, ".irq"}, {15'h0, irq}, {15'h0, e.irq});
    endtask

    task automatic do_reset();
        @(negedge read_clk);
        read_bus  = A_NONE;
        src_valid = 4'b0000;
        reset     = 1'b1;
        @(negedge read_clk);
        reset     = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        if (v.rst_before) do_reset();
        @(negedge read_clk);
        read_bus  = v.addr;
        src_valid = v.valid;
        src_data  = v.data;
        sb.push_back('{bus: v.exp_bus, pop: v.exp_pop, irq: v.exp_irq, name: v.name});
        @(posedge read_clk);
        #1;
        compare_head();
    endtask

    initial begin
        reset     = 1'b1;
        read_bus  = A_NONE;
        src_valid = 4'b0000;
        src_data  = 32'h0;

        // Reset state, observed while reset is still asserted
        #3;
        check("reset.bus", data_bus, BUS_Z);
        check("reset.pop", {12'h0, src_pop}, 16'h0);
        check("reset.irq", {15'h0, irq}, 16'h0);
        @(negedge read_clk);
        reset = 1'b0;

        // rst, addr, valid, data, bus, pop, irq, name
        tbl.push_back('{1'b0, A_POP,  4'b0000, 32'h0,        16'h0000, 4'b0000, 1'b0, "t1_empty_pop"});
        tbl.push_back('{1'b0, A_POP,  4'b0101, 32'h00420041, 16'h8041, 4'b0001, 1'b1, "t2_pop_src0"});
        tbl.push_back('{1'b0, A_POP,  4'b0101, 32'h00420041, 16'h8242, 4'b0100, 1'b1, "t2_pop_src2"});
        tbl.push_back('{1'b0, A_NONE, 4'b0000, 32'h00420041, BUS_Z,    4'b0000, 1'b0, "t2_idle"});
        tbl.push_back('{1'b1, A_POP,  4'b1111, D_ALL,        16'h80A0, 4'b0001, 1'b1, "t3_rr0"});
        tbl.push_back('{1'b0, A_POP,  4'b1111, D_ALL,        16'h81B1, 4'b0010, 1'b1, "t3_rr1"});
        tbl.push_back('{1'b0, A_POP,  4'b1111, D_ALL,        16'h82C2, 4'b0100, 1'b1, "t3_rr2"});
        tbl.push_back('{1'b0, A_POP,  4'b1111, D_ALL,        16'h83D3, 4'b1000, 1'b1, "t3_rr3"});
        tbl.push_back('{1'b0, A_POP,  4'b1111, D_ALL,        16'h80A0, 4'b0001, 1'b1, "t3_wrap0"});
        tbl.push_back('{1'b0, A_POP,  4'b1111, D_ALL,        16'h81B1, 4'b0010, 1'b1, "t3_wrap1"});
        tbl.push_back('{1'b0, A_POP,  4'b1111, D_ALL,        16'h82C2, 4'b0100, 1'b1, "t3_wrap2"});
        tbl.push_back('{1'b0, A_POP,  4'b1111, D_ALL,        16'h83D3, 4'b1000, 1'b1, "t3_wrap3"});
        tbl.push_back('{1'b0, A_STAT, 4'b1010, D_ALL,        16'h000A, 4'b0000, 1'b1, "t4_status"});
        tbl.push_back('{1'b0, A_POP,  4'b1010, D_ALL,        16'h81B1, 4'b0010, 1'b1, "t4_pop_src1"});
        tbl.push_back('{1'b0, A_NONE, 4'b0000, D_ALL,        BUS_Z,    4'b0000, 1'b0, "t6_other0"});
        tbl.push_back('{1'b0, A_NONE, 4'b0100, D_ALL,        BUS_Z,    4'b0000, 1'b1, "t6_irq_rise"});
        tbl.push_back('{1'b0, A_NONE, 4'b0000, D_ALL,        BUS_Z,    4'b0000, 1'b0, "t6_irq_fall"});
        tbl.push_back('{1'b0, A_POP,  4'b1111, D_ALL,        16'h82C2, 4'b0100, 1'b1, "t6_state_kept"});
        tbl.push_back('{1'b0, A_POP,  4'b0000, D_ALL,        16'h0000, 4'b0000, 1'b0, "t6_none_elig"});
        tbl.push_back('{1'b0, A_POP,  4'b1111, D_ALL,        16'h83D3, 4'b1000, 1'b1, "t6_last_kept"});

        foreach (tbl[k]) apply(tbl[k]);

        // Reset while the bus is driven and a pop pulse is live
        do_reset();
        @(negedge read_clk);
        read_bus  = A_POP;
        src_valid = 4'b1111;
        src_data  = D_ALL;
        sb.push_back('{bus: 16'h80A0, pop: 4'b0001, irq: 1'b1, name: "t5_pre_reset"});
        @(posedge read_clk);
        #1;
        compare_head();
        reset = 1'b1;
        #1;
        check("t5_bus_released", data_bus, BUS_Z);
        check("t5_pop_cancelled", {12'h0, src_pop}, 16'h0);
        @(posedge read_clk);
        #1;
        check("t5_pop_held_low", {12'h0, src_pop}, 16'h0);
        check("t5_bus_held_z", data_bus, BUS_Z);
        @(negedge read_clk);
        reset = 1'b0;
        sb.push_back('{bus: 16'h80A0, pop: 4'b0001, irq: 1'b1, name: "t5_first_after"});
        @(posedge read_clk);
        #1;
        compare_head();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
